// File: rtl/de_stage_pkg.sv
// Shared decode-stage definitions: RV32I opcodes, op_class encoding,
// FE/DE latch layouts and the bus canary.
package de_stage_pkg;

  localparam int DBITS    = 32;
  localparam int REGNO    = 32;
  localparam int CANARY_W = 16;
  localparam logic [CANARY_W-1:0] CANARY_VAL = 16'hCAFE;

  // FE latch is {inst, pc, pcplus, inst_count, canary}, canary in the LSBs.
  localparam int FE_W          = 4*DBITS + CANARY_W;
  localparam int FE_CANARY_LSB = 0;
  localparam int FE_COUNT_LSB  = CANARY_W;
  localparam int FE_PCPLUS_LSB = CANARY_W + DBITS;
  localparam int FE_PC_LSB     = CANARY_W + 2*DBITS;
  localparam int FE_INST_LSB   = CANARY_W + 3*DBITS;

  localparam int DE_W = 1 + 4 + 3 + 1 + 5 + 1 + 6*DBITS + CANARY_W;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_OP     = 4'd1,
    CLS_OP_IMM = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } op_class_e;

  typedef struct packed {
    logic                valid;
    op_class_e           op_class;
    logic [2:0]          funct3;
    logic                inst30;
    logic [4:0]          rd;
    logic                wr_reg;
    logic [DBITS-1:0]    rs1_val;
    logic [DBITS-1:0]    rs2_val;
    logic [DBITS-1:0]    imm;
    logic [DBITS-1:0]    pc;
    logic [DBITS-1:0]    pcplus;
    logic [DBITS-1:0]    inst_count;
    logic [CANARY_W-1:0] canary;
  } de_latch_t;

  // Unknown opcodes decode to NOP; no legal opcode maps there.
  function automatic op_class_e decode_class(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:     return CLS_OP;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      default:    return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/de_regfile.sv
// 32x32 architectural register file: two combinational write-first read
// ports, one write port, x0 tied to zero.
module de_regfile
  import de_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [4:0]       i_wr_addr,
  input  logic [DBITS-1:0] i_wr_data,
  input  logic [4:0]       i_rd_addr1,
  input  logic [4:0]       i_rd_addr2,
  output logic [DBITS-1:0] o_rd_data1,
  output logic [DBITS-1:0] o_rd_data2
);

  logic [DBITS-1:0] r_regs [REGNO];
  logic             w_wr_ok;

  assign w_wr_ok = i_wr_en && (i_wr_addr != 5'd0);

  // NOTE: the array is reset because software may read any register right
  // after reset and must see 0; this keeps it in flops rather than a RAM.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGNO; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data1 = r_regs[i_rd_addr1];
    if (i_rd_addr1 == 5'd0)                          o_rd_data1 = '0;
    else if (w_wr_ok && (i_wr_addr == i_rd_addr1))   o_rd_data1 = i_wr_data;
  end

  always_comb begin
    o_rd_data2 = r_regs[i_rd_addr2];
    if (i_rd_addr2 == 5'd0)                          o_rd_data2 = '0;
    else if (w_wr_ok && (i_wr_addr == i_rd_addr2))   o_rd_data2 = i_wr_data;
  end

endmodule

// File: rtl/de_stage.sv
// RV32I decode stage: decodes the FE latch, reads operands, tracks busy
// registers, stalls FE on hazards and issues into the DE latch.
module de_stage
  import de_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [FE_W-1:0]  from_FE_latch,
  input  logic             agex_redirect,
  input  logic             wb_wr_en,
  input  logic [4:0]       wb_rd,
  input  logic [DBITS-1:0] wb_data,
  output logic             stall_to_FE,
  output logic [DE_W-1:0]  DE_latch_out,
  output logic             illegal_seen
);

  logic [DBITS-1:0]    w_inst, w_pc, w_pcplus, w_inst_count;
  logic [CANARY_W-1:0] w_canary;
  logic                w_in_valid;
  logic [4:0]          w_rd, w_rs1, w_rs2;
  op_class_e           w_class;
  logic                w_use_rs1, w_use_rs2, w_writes_rd, w_wr_reg;
  logic [DBITS-1:0]    w_imm, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [DBITS-1:0]    w_rs1_val, w_rs2_val;
  logic [REGNO-1:0]    w_wb_onehot, w_busy_eff, w_issue_set;
  logic                w_hazard, w_issue;
  de_latch_t           w_de_next;

  logic [REGNO-1:0]    r_busy;
  de_latch_t           r_de;
  logic                r_illegal;

  assign w_inst       = from_FE_latch[FE_INST_LSB   +: DBITS];
  assign w_pc         = from_FE_latch[FE_PC_LSB     +: DBITS];
  assign w_pcplus     = from_FE_latch[FE_PCPLUS_LSB +: DBITS];
  assign w_inst_count = from_FE_latch[FE_COUNT_LSB  +: DBITS];
  assign w_canary     = from_FE_latch[FE_CANARY_LSB +: CANARY_W];
  assign w_in_valid   = (w_canary == CANARY_VAL);

  assign w_rd  = w_inst[11:7];
  assign w_rs1 = w_inst[19:15];
  assign w_rs2 = w_inst[24:20];

  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'd0};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_class     = decode_class(w_inst[6:0]);
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_writes_rd = 1'b0;
    w_imm       = '0;
    case (w_class)
      CLS_OP:     begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_writes_rd = 1'b1; end
      CLS_OP_IMM: begin w_use_rs1 = 1'b1; w_writes_rd = 1'b1; w_imm = w_imm_i; end
      CLS_LOAD:   begin w_use_rs1 = 1'b1; w_writes_rd = 1'b1; w_imm = w_imm_i; end
      CLS_STORE:  begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_s; end
      CLS_BRANCH: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_b; end
      CLS_JAL:    begin w_writes_rd = 1'b1; w_imm = w_imm_j; end
      CLS_JALR:   begin w_use_rs1 = 1'b1; w_writes_rd = 1'b1; w_imm = w_imm_i; end
      CLS_LUI:    begin w_writes_rd = 1'b1; w_imm = w_imm_u; end
      CLS_AUIPC:  begin w_writes_rd = 1'b1; w_imm = w_imm_u; end
      default:    ;
    endcase
  end

  assign w_wr_reg = w_writes_rd && (w_rd != 5'd0);

  de_regfile u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (wb_wr_en),
    .i_wr_addr  (wb_rd),
    .i_wr_data  (wb_data),
    .i_rd_addr1 (w_rs1),
    .i_rd_addr2 (w_rs2),
    .o_rd_data1 (w_rs1_val),
    .o_rd_data2 (w_rs2_val)
  );

  // A same-cycle WB releases its register, matching the write-first bypass.
  assign w_wb_onehot = wb_wr_en ? ({{(REGNO-1){1'b0}}, 1'b1} << wb_rd) : '0;
  assign w_busy_eff  = r_busy & ~w_wb_onehot;

  assign w_hazard = w_in_valid && ((w_use_rs1 && w_busy_eff[w_rs1]) ||
                                   (w_use_rs2 && w_busy_eff[w_rs2]) ||
                                   (w_wr_reg  && w_busy_eff[w_rd]));

  assign stall_to_FE = w_hazard && !agex_redirect;
  assign w_issue     = w_in_valid && !w_hazard && !agex_redirect;
  assign w_issue_set = (w_issue && w_wr_reg) ? ({{(REGNO-1){1'b0}}, 1'b1} << w_rd) : '0;

  always_comb begin
    w_de_next = '0;
    if (w_issue) begin
      w_de_next.valid      = 1'b1;
      w_de_next.op_class   = w_class;
      w_de_next.funct3     = w_inst[14:12];
      w_de_next.inst30     = w_inst[30];
      w_de_next.rd         = w_rd;
      w_de_next.wr_reg     = w_wr_reg;
      w_de_next.rs1_val    = w_rs1_val;
      w_de_next.rs2_val    = w_rs2_val;
      w_de_next.imm        = w_imm;
      w_de_next.pc         = w_pc;
      w_de_next.pcplus     = w_pcplus;
      w_de_next.inst_count = w_inst_count;
      w_de_next.canary     = CANARY_VAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= '0;
      r_de      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_busy    <= ((r_busy & ~w_wb_onehot) | w_issue_set) & ~{{(REGNO-1){1'b0}}, 1'b1};
      r_de      <= w_de_next;
      r_illegal <= r_illegal || (w_in_valid && !agex_redirect && (w_class == CLS_NOP));
    end
  end

  assign DE_latch_out = r_de;
  assign illegal_seen = r_illegal;

endmodule

// File: tb/tb_de_stage.sv
// Directed bench for de_stage: decode table plus hazard, redirect, WAW,
// x0, invalid-input, illegal-opcode and reset sequences.
module tb_de_stage;
  import de_stage_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        b30;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcplus;
    logic [31:0] cnt;
    logic [15:0] canary;
  } de_view_t;

  typedef struct {
    logic [31:0] inst;
    op_class_e   cls;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        b30;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [143:0] from_FE_latch;
  logic         agex_redirect;
  logic         wb_wr_en;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         stall_to_FE;
  logic [222:0] DE_latch_out;
  logic         illegal_seen;

  de_view_t de;
  assign de = DE_latch_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] icount  = 32'd1;
  vec_t        vecs [12];

  de_stage dut (
    .clk           (clk),
    .reset         (reset),
    .from_FE_latch (from_FE_latch),
    .agex_redirect (agex_redirect),
    .wb_wr_en      (wb_wr_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .stall_to_FE   (stall_to_FE),
    .DE_latch_out  (DE_latch_out),
    .illegal_seen  (illegal_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fe_inst(input logic [31:0] inst, input logic [31:0] pc);
    from_FE_latch = {inst, pc, pc + 32'd4, icount, 16'hCAFE};
    icount = icount + 32'd1;
  endtask

  task automatic fe_bubble();
    from_FE_latch = '0;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_wr_en = en;
    wb_rd    = rd;
    wb_data  = data;
  endtask

  task automatic check_bubble(input string name);
    check(name, 32'(|DE_latch_out), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h00000013, CLS_OP_IMM, 5'd0,  1'b0, 32'h00000000, 3'd0, 1'b0}; // addi x0,x0,0
    vecs[1]  = '{32'h00000233, CLS_OP,     5'd4,  1'b1, 32'h00000000, 3'd0, 1'b0}; // add x4,x0,x0
    vecs[2]  = '{32'h40000233, CLS_OP,     5'd4,  1'b1, 32'h00000000, 3'd0, 1'b1}; // sub x4,x0,x0
    vecs[3]  = '{32'h80000063, CLS_BRANCH, 5'd0,  1'b0, 32'hFFFFF000, 3'd0, 1'b0}; // beq -4096
    vecs[4]  = '{32'h002000EF, CLS_JAL,    5'd1,  1'b1, 32'h00000002, 3'd0, 1'b0}; // jal x1,+2
    vecs[5]  = '{32'hFE002FA3, CLS_STORE,  5'd31, 1'b0, 32'hFFFFFFFF, 3'd2, 1'b1}; // sw x0,-1(x0)
    vecs[6]  = '{32'hFF802283, CLS_LOAD,   5'd5,  1'b1, 32'hFFFFFFF8, 3'd2, 1'b1}; // lw x5,-8(x0)
    vecs[7]  = '{32'hFFFFF397, CLS_AUIPC,  5'd7,  1'b1, 32'hFFFFF000, 3'd7, 1'b1}; // auipc x7,0xFFFFF
    vecs[8]  = '{32'h00C00367, CLS_JALR,   5'd6,  1'b1, 32'h0000000C, 3'd0, 1'b0}; // jalr x6,12(x0)
    vecs[9]  = '{32'h123451B7, CLS_LUI,    5'd3,  1'b1, 32'h12345000, 3'd5, 1'b0}; // lui x3,0x12345
    vecs[10] = '{32'h00001463, CLS_BRANCH, 5'd8,  1'b0, 32'h00000008, 3'd1, 1'b0}; // bne +8
    vecs[11] = '{32'h801FF06F, CLS_JAL,    5'd0,  1'b0, 32'hFFFFF800, 3'd7, 1'b0}; // jal x0,-2048

    reset = 1'b1;
    agex_redirect = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    fe_bubble();
    tick();
    tick();
    check_bubble("reset_latch");
    check("reset_stall", 32'(stall_to_FE), 32'd0);
    check("reset_illegal", 32'(illegal_seen), 32'd0);
    reset = 1'b0;

    // addi x1,x0,5 issues with 1-cycle latency
    fe_inst(32'h00500093, 32'h100);
    #1 check("addi_stall", 32'(stall_to_FE), 32'd0);
    tick();
    check("addi_valid", 32'(de.valid), 32'd1);
    check("addi_class", 32'(de.cls), 32'(CLS_OP_IMM));
    check("addi_rd", 32'(de.rd), 32'd1);
    check("addi_imm", de.imm, 32'd5);
    check("addi_wr", 32'(de.wr), 32'd1);
    check("addi_pc", de.pc, 32'h100);
    check("addi_pcplus", de.pcplus, 32'h104);
    check("addi_cnt", de.cnt, 32'd1);
    check("addi_canary", 32'(de.canary), 32'h0000CAFE);

    // RAW on x1: add x2,x1,x1 stalls until WB x1
    fe_inst(32'h00108133, 32'h104);
    #1 check("raw_stall0", 32'(stall_to_FE), 32'd1);
    tick();
    check_bubble("raw_bubble0");
    check("raw_stall1", 32'(stall_to_FE), 32'd1);
    tick();
    check_bubble("raw_bubble1");
    wb(1'b1, 5'd1, 32'd5);
    #1 check("raw_wb_stall", 32'(stall_to_FE), 32'd0);
    tick();
    check("raw_valid", 32'(de.valid), 32'd1);
    check("raw_class", 32'(de.cls), 32'(CLS_OP));
    check("raw_rs1", de.rs1_val, 32'd5);
    check("raw_rs2", de.rs2_val, 32'd5);
    check("raw_rd", 32'(de.rd), 32'd2);
    wb(1'b0, 5'd0, 32'd0);
    fe_bubble();

    // Redirect during hazard on x2 (busy from the add)
    fe_inst(32'h00010233, 32'h200); // add x4,x2,x0
    #1 check("redir_pre_stall", 32'(stall_to_FE), 32'd1);
    agex_redirect = 1'b1;
    #1 check("redir_stall", 32'(stall_to_FE), 32'd0);
    tick();
    check_bubble("redir_bubble");
    agex_redirect = 1'b0;
    #1 check("redir_busy_kept", 32'(stall_to_FE), 32'd1);
    wb(1'b1, 5'd2, 32'h22);
    #1 check("redir_wb_stall", 32'(stall_to_FE), 32'd0);
    tick();
    check("redir_issue_rs1", de.rs1_val, 32'h22);
    check("redir_issue_rd", 32'(de.rd), 32'd4);
    wb(1'b0, 5'd0, 32'd0);
    fe_bubble();
    wb(1'b1, 5'd4, 32'h44);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // Registered (non-bypassed) reads: add x6,x1,x2
    fe_inst(32'h00208333, 32'h300);
    tick();
    check("rf_rs1", de.rs1_val, 32'd5);
    check("rf_rs2", de.rs2_val, 32'h22);
    fe_bubble();
    wb(1'b1, 5'd6, 32'h66);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // WAW: lui x3 twice
    fe_inst(32'h123451B7, 32'h400);
    tick();
    check("waw_first_imm", de.imm, 32'h12345000);
    #1 check("waw_stall", 32'(stall_to_FE), 32'd1);
    tick();
    check_bubble("waw_bubble");
    wb(1'b1, 5'd3, 32'h33);
    #1 check("waw_wb_stall", 32'(stall_to_FE), 32'd0);
    tick();
    check("waw_valid", 32'(de.valid), 32'd1);
    check("waw_class", 32'(de.cls), 32'(CLS_LUI));
    check("waw_imm", de.imm, 32'h12345000);
    wb(1'b0, 5'd0, 32'd0);
    fe_bubble();
    wb(1'b1, 5'd3, 32'h33);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // Decode table
    for (int i = 0; i < 12; i++) begin
      fe_inst(vecs[i].inst, 32'h1000 + 32'(i) * 32'd4);
      #1 check($sformatf("v%0d_stall", i), 32'(stall_to_FE), 32'd0);
      tick();
      check($sformatf("v%0d_valid", i), 32'(de.valid), 32'd1);
      check($sformatf("v%0d_class", i), 32'(de.cls), 32'(vecs[i].cls));
      check($sformatf("v%0d_rd", i), 32'(de.rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_wr", i), 32'(de.wr), 32'(vecs[i].wr));
      check($sformatf("v%0d_imm", i), de.imm, vecs[i].imm);
      check($sformatf("v%0d_f3", i), 32'(de.f3), 32'(vecs[i].f3));
      check($sformatf("v%0d_b30", i), 32'(de.b30), 32'(vecs[i].b30));
      check($sformatf("v%0d_pc", i), de.pc, 32'h1000 + 32'(i) * 32'd4);
      fe_bubble();
      if (vecs[i].wr) begin
        wb(1'b1, vecs[i].rd, 32'h0000_0A00 + 32'(i));
        tick();
        wb(1'b0, 5'd0, 32'd0);
      end
    end

    // x0: same-cycle WB to x0 is ignored, and x0 still reads 0 afterwards
    fe_inst(32'h000002B3, 32'h500); // add x5,x0,x0
    wb(1'b1, 5'd0, 32'hDEADBEEF);
    tick();
    check("x0_bypass_rs1", de.rs1_val, 32'd0);
    check("x0_bypass_rs2", de.rs2_val, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    fe_bubble();
    wb(1'b1, 5'd5, 32'h55);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    fe_inst(32'h000002B3, 32'h504);
    tick();
    check("x0_after_rs1", de.rs1_val, 32'd0);
    fe_bubble();
    wb(1'b1, 5'd5, 32'h55);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // Invalid inputs: all-zero latch, then a bad canary
    tick();
    check_bubble("zero_fe_bubble");
    check("zero_fe_valid", 32'(de.valid), 32'd0);
    from_FE_latch = {32'h00500093, 32'h600, 32'h604, icount, 16'hBEEF};
    tick();
    check_bubble("bad_canary_bubble");
    fe_inst(32'h00108133, 32'h608); // add x2,x1,x1: x1 must not be busy
    #1 check("bad_canary_no_busy", 32'(stall_to_FE), 32'd0);
    tick();
    fe_bubble();
    wb(1'b1, 5'd2, 32'h22);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // Illegal opcode 7'h7F, sticky
    check("illegal_pre", 32'(illegal_seen), 32'd0);
    fe_inst(32'h0000007F, 32'h700);
    tick();
    check("illegal_valid", 32'(de.valid), 32'd1);
    check("illegal_class", 32'(de.cls), 32'(CLS_NOP));
    check("illegal_wr", 32'(de.wr), 32'd0);
    check("illegal_imm", de.imm, 32'd0);
    check("illegal_set", 32'(illegal_seen), 32'd1);
    fe_bubble();
    tick();
    tick();
    check("illegal_held", 32'(illegal_seen), 32'd1);

    // Reset mid-stall
    fe_inst(32'h00500093, 32'h800);
    tick();
    fe_inst(32'h00108133, 32'h804);
    #1 check("rst_pre_stall", 32'(stall_to_FE), 32'd1);
    reset = 1'b1;
    #1 check("rst_stall", 32'(stall_to_FE), 32'd0);
    check("rst_illegal", 32'(illegal_seen), 32'd0);
    check_bubble("rst_latch");
    tick();
    reset = 1'b0;
    #1 check("rst_after_stall", 32'(stall_to_FE), 32'd0);
    tick();
    check("rst_issue_valid", 32'(de.valid), 32'd1);
    check("rst_issue_rs1", de.rs1_val, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
